// File: rtl/sparc_exu_thrreg_pkg.sv
// Shared types for the per-thread register bank: RMW mode encodings and the W2 pending request.
// Request fields are sized for the largest legal bank; instances use the low SIZE/NTHR bits.
package sparc_exu_thrreg_pkg;

  localparam int unsigned THRREG_MAX_SIZE = 64;
  localparam int unsigned THRREG_MAX_NTHR = 8;

  typedef enum logic [1:0] {
    THRREG_LOAD = 2'b00,
    THRREG_SET  = 2'b01,
    THRREG_CLR  = 2'b10,
    THRREG_INC  = 2'b11
  } thrreg_mode_e;

  typedef struct packed {
    logic [THRREG_MAX_NTHR-1:0] thr;
    thrreg_mode_e               mode;
    logic [THRREG_MAX_SIZE-1:0] data;
  } thrreg_req_t;

endpackage

// File: rtl/sparc_exu_thrreg_alu.sv
// Combinational read-modify-write function for one thread register.
module sparc_exu_thrreg_alu
  import sparc_exu_thrreg_pkg::*;
#(
  parameter int unsigned SIZE = 3
) (
  input  thrreg_mode_e    mode,
  input  logic [SIZE-1:0] cur,
  input  logic [SIZE-1:0] data,
  output logic [SIZE-1:0] res
);

  always_comb begin
    res = cur;
    unique case (mode)
      THRREG_LOAD: res = data;
      THRREG_SET:  res = cur | data;
      THRREG_CLR:  res = cur & ~data;
      THRREG_INC:  res = cur + data;  // modulo 2^SIZE, carry dropped
      default:     res = cur;
    endcase
  end

endmodule

// File: rtl/sparc_exu_thrreg_bank.sv
// Per-thread register bank with W-capture / W2-commit pipeline and priority read port.
// Define SPARC_EXU_THRREG_BYPASS_EN to forward the in-flight W2 result onto data_out.
module sparc_exu_thrreg_bank
  import sparc_exu_thrreg_pkg::*;
#(
  parameter int unsigned    SIZE    = 3,
  parameter int unsigned    NTHR    = 4,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NTHR-1:0] thr_out,
  input  logic            wen_w,
  input  logic [NTHR-1:0] thr_w,
  input  logic [1:0]      mode_w,
  input  logic [SIZE-1:0] data_in_w,
  input  logic            kill_w2,
  output logic [SIZE-1:0] data_out,
  output logic [NTHR-1:0] thr_vld,
  output logic            pend_w2
);

  logic [SIZE-1:0] regs_q  [NTHR];
  logic [SIZE-1:0] new_val [NTHR];
  logic [SIZE-1:0] rd_val  [NTHR];
  logic [NTHR-1:0] thr_vld_q;
  logic            pend_vld_q;
  thrreg_req_t     pend_d, pend_q;
  logic [NTHR-1:0] pend_thr;
  logic [SIZE-1:0] pend_data;
  logic            capture;
  logic            commit;

  // A request with no target thread is dropped at W.
  assign capture   = wen_w & (|thr_w);
  assign commit    = pend_vld_q & ~kill_w2;
  assign pend_thr  = pend_q.thr[NTHR-1:0];
  assign pend_data = pend_q.data[SIZE-1:0];

  // Request fields above NTHR/SIZE are always zero.
  logic unused_pend;
  assign unused_pend = (^(pend_q.thr >> NTHR)) ^ (^(pend_q.data >> SIZE));

  always_comb begin
    pend_d = pend_q;
    if (capture) begin
      pend_d      = '0;
      pend_d.thr  = THRREG_MAX_NTHR'(thr_w);
      pend_d.mode = thrreg_mode_e'(mode_w);
      pend_d.data = THRREG_MAX_SIZE'(data_in_w);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      pend_vld_q <= capture;
      pend_q     <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NTHR; t++) begin
        regs_q[t] <= RST_VAL;
      end
      thr_vld_q <= '0;
    end else if (commit) begin
      for (int t = 0; t < NTHR; t++) begin
        if (pend_thr[t]) begin
          regs_q[t]    <= new_val[t];
          thr_vld_q[t] <= 1'b1;
        end
      end
    end
  end

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    sparc_exu_thrreg_alu #(
      .SIZE (SIZE)
    ) u_alu (
      .mode (pend_q.mode),
      .cur  (regs_q[t]),
      .data (pend_data),
      .res  (new_val[t])
    );
`ifdef SPARC_EXU_THRREG_BYPASS_EN
    assign rd_val[t] = (commit && pend_thr[t]) ? new_val[t] : regs_q[t];
`else
    assign rd_val[t] = regs_q[t];
`endif
  end

  // Walk from the top down so the lowest set thr_out bit wins.
  always_comb begin
    data_out = '0;
    for (int t = NTHR - 1; t >= 0; t--) begin
      if (thr_out[t]) data_out = rd_val[t];
    end
  end

  assign thr_vld = thr_vld_q;
  assign pend_w2 = pend_vld_q;

endmodule

// File: tb/tb_sparc_exu_thrreg_bank.sv
// Directed bench for sparc_exu_thrreg_bank: stimulus queues expectations, a negedge monitor checks them.
module tb_sparc_exu_thrreg_bank;
  import sparc_exu_thrreg_pkg::*;

`ifdef SPARC_EXU_THRREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] thr_out;
  logic       wen_w;
  logic [3:0] thr_w;
  logic [1:0] mode_w;
  logic [2:0] data_in_w;
  logic       kill_w2;
  logic [2:0] data_out;
  logic [3:0] thr_vld;
  logic       pend_w2;

  sparc_exu_thrreg_bank #(
    .SIZE    (3),
    .NTHR    (4),
    .RST_VAL (3'b101)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .thr_out   (thr_out),
    .wen_w     (wen_w),
    .thr_w     (thr_w),
    .mode_w    (mode_w),
    .data_in_w (data_in_w),
    .kill_w2   (kill_w2),
    .data_out  (data_out),
    .thr_vld   (thr_vld),
    .pend_w2   (pend_w2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] data;
    logic [3:0] vld;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic cmp(input string name, input string field, input logic [7:0] act,
                     input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, "data_out", 8'(data_out), 8'(e.data));
      cmp(e.name, "thr_vld", 8'(thr_vld), 8'(e.vld));
      cmp(e.name, "pend_w2", 8'(pend_w2), 8'(e.pend));
    end
  end

  task automatic push_exp(input string name, input logic [2:0] d, input logic [3:0] v,
                          input logic p);
    exp_t e;
    e.name = name;
    e.data = d;
    e.vld  = v;
    e.pend = p;
    q.push_back(e);
  endtask

  task automatic drive(input logic w, input logic [3:0] t, input logic [1:0] m,
                       input logic [2:0] d, input logic k, input logic [3:0] ro);
    wen_w     = w;
    thr_w     = t;
    mode_w    = m;
    data_in_w = d;
    kill_w2   = k;
    thr_out   = ro;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    reset = 1'b1;
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0000);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state on every thread and with no thread selected
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'(1 << i));
      push_exp("rst_rd", 3'd5, 4'b0000, 1'b0);
      cyc();
    end
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0000);
    push_exp("rst_none", 3'd0, 4'b0000, 1'b0);
    cyc();

    // Load thread 2 with 6
    drive(1, 4'b0100, THRREG_LOAD, 3'd6, 0, 4'b0100);
    push_exp("ld_w", 3'd5, 4'b0000, 1'b0);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0100);
    push_exp("ld_w2", BYP ? 3'd6 : 3'd5, 4'b0000, 1'b1);
    cyc();
    push_exp("ld_done", 3'd6, 4'b0100, 1'b0);
    cyc();

    // Request with no target is dropped
    drive(1, 4'b0000, THRREG_LOAD, 3'd3, 0, 4'b0100);
    push_exp("drop_w", 3'd6, 4'b0100, 1'b0);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0100);
    push_exp("drop_w2", 3'd6, 4'b0100, 1'b0);
    cyc();

    // Killed load to thread 1
    drive(1, 4'b0010, THRREG_LOAD, 3'd3, 0, 4'b0010);
    push_exp("kill_w", 3'd5, 4'b0100, 1'b0);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 1, 4'b0010);
    push_exp("kill_w2", 3'd5, 4'b0100, 1'b1);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0010);
    push_exp("kill_done", 3'd5, 4'b0100, 1'b0);
    cyc();

    // Thread 0: load 7, then +1 (wraps to 0), then +3, all back-to-back
    drive(1, 4'b0001, THRREG_LOAD, 3'd7, 0, 4'b0001);
    push_exp("inc_ld_w", 3'd5, 4'b0100, 1'b0);
    cyc();
    drive(1, 4'b0001, THRREG_INC, 3'd1, 0, 4'b0001);
    push_exp("inc_ld_w2", BYP ? 3'd7 : 3'd5, 4'b0100, 1'b1);
    cyc();
    drive(1, 4'b0001, THRREG_INC, 3'd3, 0, 4'b0001);
    push_exp("inc1_w2", BYP ? 3'd0 : 3'd7, 4'b0101, 1'b1);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0001);
    push_exp("inc2_w2", BYP ? 3'd3 : 3'd0, 4'b0101, 1'b1);
    cyc();
    push_exp("inc_done", 3'd3, 4'b0101, 1'b0);
    cyc();

    // Load {1,2,4,0}, then broadcast set of 3'b010 chained directly behind
    drive(1, 4'b0001, THRREG_LOAD, 3'd1, 0, 4'b0001);
    push_exp("bc_ld0", 3'd3, 4'b0101, 1'b0);
    cyc();
    drive(1, 4'b0010, THRREG_LOAD, 3'd2, 0, 4'b0001);
    push_exp("bc_ld1", BYP ? 3'd1 : 3'd3, 4'b0101, 1'b1);
    cyc();
    drive(1, 4'b0100, THRREG_LOAD, 3'd4, 0, 4'b0010);
    push_exp("bc_ld2", BYP ? 3'd2 : 3'd5, 4'b0101, 1'b1);
    cyc();
    drive(1, 4'b1000, THRREG_LOAD, 3'd0, 0, 4'b0100);
    push_exp("bc_ld3", BYP ? 3'd4 : 3'd6, 4'b0111, 1'b1);
    cyc();
    drive(1, 4'b1111, THRREG_SET, 3'b010, 0, 4'b1000);
    push_exp("bc_set_w", BYP ? 3'd0 : 3'd5, 4'b0111, 1'b1);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b1000);
    push_exp("bc_set_w2", BYP ? 3'd2 : 3'd0, 4'b1111, 1'b1);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0001);
    push_exp("bc_t0", 3'd3, 4'b1111, 1'b0);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0010);
    push_exp("bc_t1", 3'd2, 4'b1111, 1'b0);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0100);
    push_exp("bc_t2", 3'd6, 4'b1111, 1'b0);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b1000);
    push_exp("bc_t3", 3'd2, 4'b1111, 1'b0);
    cyc();

    // Multi-hot read select picks the lowest thread
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0110);
    push_exp("rd_prio", 3'd2, 4'b1111, 1'b0);
    cyc();

    // Reset asserted during W2 of a load to thread 3
    drive(1, 4'b1000, THRREG_LOAD, 3'd1, 0, 4'b1000);
    push_exp("rstw2_w", 3'd2, 4'b1111, 1'b0);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b1000);
    #1 reset = 1'b1;
    push_exp("rstw2_async", 3'd5, 4'b0000, 1'b0);
    cyc();
    push_exp("rstw2_hold", 3'd5, 4'b0000, 1'b0);
    cyc();
    reset = 1'b0;
    push_exp("rstw2_t3", 3'd5, 4'b0000, 1'b0);
    cyc();
    drive(0, 4'b0000, THRREG_LOAD, 3'd0, 0, 4'b0001);
    push_exp("rstw2_t0", 3'd5, 4'b0000, 1'b0);
    cyc();

    cyc();
    cyc();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
